// File: rtl/ex_stage_mdu_pkg.sv
// ex_stage_mdu_pkg: shared definitions for the execute stage.
//   - op_e        : operation encodings (11 ALU ops, 8 RV32M ops; bit 4 marks RV32M)
//   - mdu_state_e : states of the iterative multiply/divide sequencer
//   - RST_ENABLE  : active level of the reset input
//   - is_mdu / is_mul / is_div : opcode class predicates
package ex_stage_mdu_pkg;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SRL    = 5'd3,
        OP_SRA    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_XOR    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX
    } mdu_state_e;

    function automatic logic is_mdu(input logic [4:0] op);
        return op[4] && (op[3] == 1'b0);
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return is_mdu(op) && (op[2] == 1'b0);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return is_mdu(op) && op[2];
    endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if: ID/EX-side request and EX/MEM-side result bundle.
//   master : issues ops (flush_in, valid_in, op_in, rdE_in, rdIdx_in, rs1/rs2 data)
//            and observes ready_out, valid_out, rdE_out, rdIdx_out, rdData_out, busy_out
//   slave  : the execute stage itself (directions reversed)
interface ex_stage_mdu_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int OP_W      = 5
) ();
    logic                 flush_in;
    logic                 valid_in;
    logic                 ready_out;
    logic [OP_W-1:0]      op_in;
    logic                 rdE_in;
    logic [REG_IDX_W-1:0] rdIdx_in;
    logic [XLEN-1:0]      rs1Data_in;
    logic [XLEN-1:0]      rs2Data_in;
    logic                 valid_out;
    logic                 rdE_out;
    logic [REG_IDX_W-1:0] rdIdx_out;
    logic [XLEN-1:0]      rdData_out;
    logic                 busy_out;

    modport master (
        output flush_in, valid_in, op_in, rdE_in, rdIdx_in, rs1Data_in, rs2Data_in,
        input  ready_out, valid_out, rdE_out, rdIdx_out, rdData_out, busy_out
    );

    modport slave (
        input  flush_in, valid_in, op_in, rdE_in, rdIdx_in, rs1Data_in, rs2Data_in,
        output ready_out, valid_out, rdE_out, rdIdx_out, rdData_out, busy_out
    );
endinterface

// File: rtl/ex_stage_mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   start         : load op/operands (only honoured in IDLE)
//   flush         : abandon any operation, return to IDLE, suppress done
//   op, a, b      : operation and raw operands
//   busy          : high in PREP, ITER and FIX
//   done, result  : one-cycle pulse in FIX with the signed/selected result
// One shared 2*XLEN accumulator holds {hi, lo} for shift-add multiply and
// {remainder, quotient} for restoring division.
module mdu_iter
    import ex_stage_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    mdu_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt;
    op_e                op_q;
    logic [2*XLEN-1:0]  acc, acc_mul, acc_div, prod;
    logic [XLEN-1:0]    opb, a_raw, mag_a, mag_b, quo, rem;
    logic [XLEN:0]      mul_sum, div_rs, div_diff;
    logic               a_neg, b_neg, sign_q, sign_r, div_zero, div_ovf, fast;

    // PREP: raw operands sit in acc[XLEN-1:0] and opb since the accept edge
    always_comb begin
        a_raw    = acc[XLEN-1:0];
        a_neg    = a_raw[XLEN-1] && (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg    = opb[XLEN-1]   && (op_q inside {OP_MULH, OP_DIV, OP_REM});
        mag_a    = a_neg ? -a_raw : a_raw;
        mag_b    = b_neg ? -opb   : opb;
        div_zero = is_div(op_q) && (opb == '0);
        div_ovf  = (op_q inside {OP_DIV, OP_REM}) &&
                   (a_raw == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
        fast     = div_zero || div_ovf;
    end

    // ITER: one multiplier bit or one quotient bit per cycle
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        acc_mul  = {mul_sum, acc[XLEN-1:1]};
        div_rs   = acc[2*XLEN-1:XLEN-1];
        div_diff = div_rs - {1'b0, opb};
        // a borrow out of the top bit means the trial subtraction went negative: restore
        acc_div  = div_diff[XLEN] ? {div_rs[XLEN-1:0],   acc[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // FIX: apply signs and pick the requested half
    always_comb begin
        prod = sign_q ? -acc : acc;
        quo  = sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sign_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_PREP;
            ST_PREP: state_n = fast ? ST_FIX : ST_ITER;
            ST_ITER: if (cnt == LAST) state_n = ST_FIX;
            ST_FIX: begin
                state_n = ST_IDLE;
                done    = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush) begin
            state_n = ST_IDLE;
            done    = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == ST_PREP) cnt <= '0;
            else if (state == ST_ITER) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (start) begin
                acc  <= {{XLEN{1'b0}}, a};
                opb  <= b;
                op_q <= op;
            end
            ST_PREP: begin
                opb <= mag_b;
                if (div_zero) begin
                    acc    <= {a_raw, {XLEN{1'b1}}};
                    sign_q <= 1'b0;
                    sign_r <= 1'b0;
                end else if (div_ovf) begin
                    acc    <= {{XLEN{1'b0}}, a_raw};
                    sign_q <= 1'b0;
                    sign_r <= 1'b0;
                end else begin
                    acc    <= {{XLEN{1'b0}}, mag_a};
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                end
            end
            ST_ITER: acc <= is_mul(op_q) ? acc_mul : acc_div;
            default: ;
        endcase
    end
endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: RISC-V execute stage with a registered single-cycle ALU and
// an iterative RV32M multiply/divide unit.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : op request with valid/ready handshake and flush,
//                    one-cycle valid_out pulse with rd write-back, busy_out
// ALU results appear one cycle after accept; MUL/DIV take XLEN+2 cycles
// (2 for divide-by-zero and signed overflow) with ready_out held low.
module ex_stage_mdu
    import ex_stage_mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int OP_W      = 5
) (
    input  logic         clk_in,
    input  logic         rst_in,
    ex_stage_mdu_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    logic                     rst, accept, wr_en, mdu_busy, mdu_done;
    op_e                      op;
    logic [SH_W-1:0]          shamt;
    logic signed [XLEN-1:0]   a_s, b_s;
    logic [XLEN-1:0]          alu_res, mdu_res;
    logic                     pend_we;
    logic [REG_IDX_W-1:0]     pend_idx;

    assign rst    = (rst_in == RST_ENABLE);
    assign op     = op_e'(bus.op_in[4:0]);
    assign accept = bus.valid_in && !mdu_busy && !bus.flush_in;
    assign wr_en  = bus.rdE_in && (bus.rdIdx_in != '0);
    assign shamt  = bus.rs2Data_in[SH_W-1:0];
    assign a_s    = signed'(bus.rs1Data_in);
    assign b_s    = signed'(bus.rs2Data_in);

    always_comb begin
        case (op)
            OP_ADD:  alu_res = bus.rs1Data_in + bus.rs2Data_in;
            OP_SUB:  alu_res = bus.rs1Data_in - bus.rs2Data_in;
            OP_SLL:  alu_res = bus.rs1Data_in << shamt;
            OP_SRL:  alu_res = bus.rs1Data_in >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.rs1Data_in < bus.rs2Data_in)};
            OP_XOR:  alu_res = bus.rs1Data_in ^ bus.rs2Data_in;
            OP_OR:   alu_res = bus.rs1Data_in | bus.rs2Data_in;
            OP_AND:  alu_res = bus.rs1Data_in & bus.rs2Data_in;
            OP_LUI:  alu_res = bus.rs1Data_in;
            default: alu_res = '0;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk_in),
        .rst    (rst),
        .start  (accept && is_mdu(op)),
        .flush  (bus.flush_in),
        .op     (op),
        .a      (bus.rs1Data_in),
        .b      (bus.rs2Data_in),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_res)
    );

    assign bus.ready_out = !mdu_busy;
    assign bus.busy_out  = mdu_busy;

    // Output stage: rdData_out/rdIdx_out hold between pulses, rdE_out only with valid_out
    always_ff @(posedge clk_in) begin
        if (rst) begin
            bus.valid_out  <= 1'b0;
            bus.rdE_out    <= 1'b0;
            bus.rdIdx_out  <= '0;
            bus.rdData_out <= '0;
            pend_we        <= 1'b0;
            pend_idx       <= '0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.rdE_out   <= 1'b0;
            if (accept && is_mdu(op)) begin
                pend_we  <= wr_en;
                pend_idx <= bus.rdIdx_in;
            end
            if (accept && !is_mdu(op)) begin
                bus.valid_out  <= 1'b1;
                bus.rdE_out    <= wr_en;
                bus.rdIdx_out  <= bus.rdIdx_in;
                bus.rdData_out <= alu_res;
            end
            if (mdu_done) begin
                bus.valid_out  <= 1'b1;
                bus.rdE_out    <= pend_we;
                bus.rdIdx_out  <= pend_idx;
                bus.rdData_out <= mdu_res;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed self-checking bench for ex_stage_mdu.
module tb_ex_stage_mdu;
    import ex_stage_mdu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ex_stage_mdu_if #(.XLEN(32), .REG_IDX_W(5), .OP_W(5)) bus ();

    ex_stage_mdu #(.XLEN(32), .REG_IDX_W(5), .OP_W(5)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
        @(negedge clk);
        bus.op_in      = op;
        bus.rs1Data_in = a;
        bus.rs2Data_in = b;
        bus.rdIdx_in   = rd;
        bus.rdE_in     = we;
        bus.valid_in   = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    // Issues an MDU op and measures edges to valid_out and cycles spent stalled+busy.
    task automatic run_mdu(input op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, output logic [31:0] res,
                           output int lat, output int low);
        issue(op, a, b, rd, 1'b1);
        lat = 0;
        low = 0;
        while (bus.valid_out !== 1'b1 && lat < 100) begin
            if (bus.ready_out === 1'b0 && bus.busy_out === 1'b1) low++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.rdData_out;
    endtask

    task automatic count_valids(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out === 1'b1) seen++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out, bus.busy_out, bus.ready_out}
            !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1})
            $display("FAIL reset: got v=%b we=%b idx=%0d d=%h busy=%b rdy=%b want 0 0 0 0 0 1",
                     bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out, bus.busy_out, bus.ready_out);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        op_e         ops [11] = '{OP_ADD, OP_SLT, OP_SLTU, OP_SUB, OP_SRA, OP_SRL, OP_SLL,
                                  OP_XOR, OP_OR, OP_AND, OP_LUI};
        logic [31:0] av  [11] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                                  32'h80000000, 32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'h12345000};
        logic [31:0] bv  [11] = '{32'd7, 32'd1, 32'd1, 32'd5, 32'd4, 32'd4, 32'h21,
                                  32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd0};
        logic [31:0] ev  [11] = '{32'd12, 32'h00000001, 32'h00000000, 32'hFFFFFFFE,
                                  32'hF8000000, 32'h08000000, 32'h00000002, 32'h0FF00FF0,
                                  32'hFFF0FFF0, 32'hF000F000, 32'h12345000};
        for (int i = 0; i < 11; i++) begin
            issue(ops[i], av[i], bv[i], 5'(i + 3), 1'b1);
            n_checks++;
            if ({bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out}
                !== {1'b1, 1'b1, 5'(i + 3), ev[i]})
                $display("FAIL alu[%0d]: got v=%b we=%b idx=%0d d=%h want 1 1 %0d %h", i,
                         bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out, i + 3, ev[i]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.rdData_out} !== {1'b0, 1'b0, 32'h12345000})
            $display("FAIL alu_hold: got v=%b we=%b d=%h want 0 0 12345000",
                     bus.valid_out, bus.rdE_out, bus.rdData_out);
        else n_pass++;
    endtask

    task automatic test_mdu();
        op_e         ops [11] = '{OP_MULHU, OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                                  OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] av  [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7,
                                  32'h80000000};
        logic [31:0] bv  [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] ev  [11] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD,
                                  32'd1, 32'd0};
        logic [31:0] r;
        int lat, low;
        for (int i = 0; i < 11; i++) begin
            run_mdu(ops[i], av[i], bv[i], 5'(i + 10), r, lat, low);
            n_checks++;
            if ({bus.rdE_out, bus.rdIdx_out, r} !== {1'b1, 5'(i + 10), ev[i]})
                $display("FAIL mdu[%0d]: got we=%b idx=%0d d=%h want 1 %0d %h", i,
                         bus.rdE_out, bus.rdIdx_out, r, i + 10, ev[i]);
            else n_pass++;
            n_checks++;
            if (lat != 34 || low != 34)
                $display("FAIL mdu_lat[%0d]: got lat=%0d stall=%0d want 34 34", i, lat, low);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.ready_out} !== 3'b001)
            $display("FAIL mdu_pulse: got v=%b we=%b rdy=%b want 0 0 1",
                     bus.valid_out, bus.rdE_out, bus.ready_out);
        else n_pass++;
    endtask

    task automatic test_div_fast();
        op_e         ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] av  [6] = '{32'd5, 32'd5, 32'd5, 32'd9, 32'h80000000, 32'h80000000};
        logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ev  [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0};
        logic [31:0] r;
        int lat, low;
        for (int i = 0; i < 6; i++) begin
            run_mdu(ops[i], av[i], bv[i], 5'd20, r, lat, low);
            n_checks++;
            if (r !== ev[i] || lat != 2 || low != 2)
                $display("FAIL div_fast[%0d]: got d=%h lat=%0d stall=%0d want %h 2 2",
                         i, r, lat, low, ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        int seen;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd9, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_in   = 1'b1;
        bus.valid_in   = 1'b1;
        bus.op_in      = OP_ADD;
        bus.rs1Data_in = 32'd1;
        bus.rs2Data_in = 32'd1;
        bus.rdIdx_in   = 5'd4;
        @(posedge clk);
        #1;
        bus.flush_in = 1'b0;
        bus.valid_in = 1'b0;
        n_checks++;
        if ({bus.ready_out, bus.busy_out, bus.valid_out} !== 3'b100)
            $display("FAIL flush_iter: got rdy=%b busy=%b v=%b want 1 0 0",
                     bus.ready_out, bus.busy_out, bus.valid_out);
        else n_pass++;
        count_valids(40, seen);
        n_checks++;
        if (seen != 0) $display("FAIL flush_drop: got %0d pulses want 0", seen);
        else n_pass++;
        issue(OP_ADD, 32'd2, 32'd3, 5'd4, 1'b1);
        n_checks++;
        if ({bus.valid_out, bus.rdIdx_out, bus.rdData_out} !== {1'b1, 5'd4, 32'd5})
            $display("FAIL flush_after: got v=%b idx=%0d d=%h want 1 4 00000005",
                     bus.valid_out, bus.rdIdx_out, bus.rdData_out);
        else n_pass++;
        // divide by zero reaches FIX one cycle after PREP; flush exactly there
        issue(OP_DIV, 32'd5, 32'd0, 5'd6, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_in = 1'b0;
        count_valids(5, seen);
        if (bus.valid_out === 1'b1) seen++;
        n_checks++;
        if (seen != 0 || bus.ready_out !== 1'b1)
            $display("FAIL flush_fix: got pulses=%0d rdy=%b want 0 1", seen, bus.ready_out);
        else n_pass++;
    endtask

    task automatic test_rd_zero();
        issue(OP_ADD, 32'd8, 32'd9, 5'd0, 1'b1);
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.rdData_out} !== {1'b1, 1'b0, 32'd17})
            $display("FAIL rd_zero: got v=%b we=%b d=%h want 1 0 00000011",
                     bus.valid_out, bus.rdE_out, bus.rdData_out);
        else n_pass++;
        issue(OP_OR, 32'h0F, 32'hF0, 5'd5, 1'b0);
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out} !== {1'b1, 1'b0, 5'd5, 32'hFF})
            $display("FAIL rd_noe: got v=%b we=%b idx=%0d d=%h want 1 0 5 000000ff",
                     bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(OP_ADD, 32'd1, 32'd2, 5'd7, 1'b1);
        issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out, bus.busy_out, bus.ready_out}
            !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1})
            $display("FAIL reset_mid: got v=%b we=%b idx=%0d d=%h busy=%b rdy=%b want 0 0 0 0 0 1",
                     bus.valid_out, bus.rdE_out, bus.rdIdx_out, bus.rdData_out, bus.busy_out, bus.ready_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        count_valids(40, seen);
        n_checks++;
        if (seen != 0) $display("FAIL reset_mid_drop: got %0d pulses want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        op_e         ops [3] = '{OP_ADD, OP_SUB, OP_XOR};
        logic [31:0] ev  [3] = '{32'd2, 32'd6, 32'h0000000F};
        logic [31:0] av  [3] = '{32'd1, 32'd10, 32'h0000000A};
        logic [31:0] bv  [3] = '{32'd1, 32'd4, 32'h00000005};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.op_in      = ops[i];
            bus.rs1Data_in = av[i];
            bus.rs2Data_in = bv[i];
            bus.rdIdx_in   = 5'(i + 1);
            bus.rdE_in     = 1'b1;
            bus.valid_in   = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.valid_out, bus.rdIdx_out, bus.rdData_out} !== {1'b1, 5'(i + 1), ev[i]})
                $display("FAIL b2b[%0d]: got v=%b idx=%0d d=%h want 1 %0d %h", i,
                         bus.valid_out, bus.rdIdx_out, bus.rdData_out, i + 1, ev[i]);
            else n_pass++;
        end
        // MUL accepted, then an ADD is held on the input and must wait for it
        @(negedge clk);
        bus.op_in      = OP_MUL;
        bus.rs1Data_in = 32'd3;
        bus.rs2Data_in = 32'd4;
        bus.rdIdx_in   = 5'd3;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.op_in      = OP_ADD;
        bus.rs1Data_in = 32'd20;
        bus.rs2Data_in = 32'd22;
        bus.rdIdx_in   = 5'd4;
        lat = 0;
        while (bus.valid_out !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if ({bus.rdIdx_out, bus.rdData_out} !== {5'd3, 32'd12} || lat != 34)
            $display("FAIL stall_mul: got idx=%0d d=%h lat=%0d want 3 0000000c 34",
                     bus.rdIdx_out, bus.rdData_out, lat);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        n_checks++;
        if ({bus.valid_out, bus.rdIdx_out, bus.rdData_out} !== {1'b1, 5'd4, 32'd42})
            $display("FAIL stall_alu: got v=%b idx=%0d d=%h want 1 4 0000002a",
                     bus.valid_out, bus.rdIdx_out, bus.rdData_out);
        else n_pass++;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.flush_in   = 1'b0;
        bus.valid_in   = 1'b0;
        bus.op_in      = '0;
        bus.rdE_in     = 1'b0;
        bus.rdIdx_in   = '0;
        bus.rs1Data_in = '0;
        bus.rs2Data_in = '0;
        test_reset();
        test_alu();
        test_mdu();
        test_div_fast();
        test_flush();
        test_rd_zero();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Parametrised execute stage for the RISC-V core: a registered single-cycle integer ALU plus an iterative multiply/divide unit (RV32M).
- Sits between ID/EX and EX/MEM.
- Accepts one operation per handshake and stalls upstream via ready_out while a multi-cycle MUL/DIV is in flight.
- Emits a one-cycle valid_out pulse carrying the rd write-back.

Parameters:
- XLEN, 32, datapath width; must be even and at least 8.
- REG_IDX_W, 5, register index width.
- OP_W, 5, opcode width (encodings in shared header).

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  synchronous, active-high reset
- flush_in  in  1  abort any in-flight op, drop current input
- valid_in  in  1  op/operands valid this cycle
- ready_out  out  1  unit can accept an op this cycle
- op_in  in  OP_W  operation code
- rdE_in  in  1  op writes rd
- rdIdx_in  in  REG_IDX_W  destination register
- rs1Data_in  in  XLEN  operand A (LUI: pre-shifted immediate)
- rs2Data_in  in  XLEN  operand B or immediate
- valid_out  out  1  result valid (one-cycle pulse)
- rdE_out  out  1  write enable to EX/MEM
- rdIdx_out  out  REG_IDX_W  destination register
- rdData_out  out  XLEN  result
- busy_out  out  1  MDU iteration in progress

Behaviour:
- Clocking and reset:
  - Clock is clk_in; reset is rst_in, synchronous and active-high.
  - On reset: state=IDLE; valid_out, rdE_out, busy_out = 0; rdIdx_out = 0; rdData_out = 0; iteration counter = 0.
- Handshake:
  - An op is accepted on a rising edge when valid_in && ready_out && !flush_in.
  - ready_out = (state==IDLE), combinational; no skid buffer.
- ALU ops (ADD SUB SLL SRL SRA SLT SLTU XOR OR AND LUI):
  - Result registered on the accept edge; valid_out=1 for the next cycle only. Latency 1.
  - Shift amount is rs2Data_in[log2(XLEN)-1:0].
  - SLT/SLTU return a zero-extended 0/1 over the full XLEN. No 1-bit truncation.
- MDU ops (MUL MULH MULHSU MULHU DIV DIVU REM REMU):
  - State machine: IDLE -> PREP (1 cycle: take magnitudes of signed operands, record result sign) -> ITER (exactly XLEN cycles, 1 bit per cycle) -> FIX (1 cycle: apply sign, select low/high product or quotient/remainder, register output) -> IDLE.
  - valid_out is high in the cycle after FIX. Total latency XLEN+2 cycles from accept.
  - busy_out is high in PREP, ITER and FIX.
  - Multiply: shift-add into a 2*XLEN accumulator. MUL returns the low half; the MULH variants return the high half.
  - Divide: restoring shift-subtract.
- Divide fast paths (resolved in PREP; skip ITER, go straight to FIX):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1; remainder = 0.
  - Fast-path latency is 2 cycles.
- Write enable:
  - rdE_out = rdE_in && (rdIdx_in != 0), captured at accept.
  - rdIdx_out and rdE_out are held from accept until valid_out.
- Hold behaviour: when valid_out=0, rdData_out holds its last value and rdE_out=0.
- Flush:
  - flush_in in any state forces state=IDLE next edge.
  - The in-flight result is discarded (no valid_out). An op presented in the same cycle is not accepted.
  - flush_in coincident with the FIX cycle also suppresses valid_out.
- rst_in has priority over flush_in. Reset mid-ITER returns to IDLE with no output.
- Back-to-back ALU ops accept every cycle. An ALU op arriving during MDU busy is stalled by ready_out=0.

Decomposition:
- Shared header (defines.vh): OP_* encodings for the 19 ops; an is-MDU predicate macro; MDU state encodings (IDLE, PREP, ITER, FIX); rstEnable=1.
- Sub-module mdu_iter, parametrised by XLEN:
  - Contains the PREP/ITER/FIX datapath and counter.
  - start/flush inputs; done pulse and result outputs.
- ex_stage_mdu holds the ALU, handshake and output registers.

Test Plan:
- Reset, then ADD rs1=5 rs2=7 rd=3 -> next cycle valid_out=1, rdData_out=12, rdIdx_out=3, rdE_out=1. SLT -1,1 -> rdData_out=32'h00000001.
- MUL 0xFFFFFFFF*0xFFFFFFFF (MULHU) -> ready_out low for 34 cycles; valid_out in cycle 34 after accept with 0xFFFFFFFE. MUL (low) gives 0x00000001.
- DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1 (0xFFFFFFFF); latency 34.
- DIV x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0. All at latency 2.
- DIVU accepted, flush_in asserted at ITER cycle 10 -> no valid_out; ready_out=1 next cycle. Subsequent ADD completes normally.
- ALU op with rdIdx_in=0, rdE_in=1 -> rdE_out=0. rst_in mid-MUL -> all outputs 0, no valid_out pulse.
